// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master among NREQ requesters.
// Optional watchdog on the WAIT state is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*7-1:0] req_addr,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [NREQ*8-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              nack,
  output logic [7:0]        rdata,
  output logic              timeout,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic              m_rw,
  output logic [7:0]        m_wdata,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_nack,
  input  logic [7:0]        m_rdata
);

  localparam int unsigned IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("i2c_req_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic            nack_q, nack_d, m_start_q, m_start_d, m_rw_q, m_rw_d;
  logic [7:0]      rdata_q, rdata_d, m_wdata_q, m_wdata_d;
  logic [6:0]      m_addr_q, m_addr_d;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  int unsigned     idx;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // First pending requester at or after the rotating pointer.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    nack_d    = nack_q;
    rdata_d   = rdata_q;
    m_start_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_rw_d    = m_rw_q;
    m_wdata_d = m_wdata_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          gnt_d     = NREQ'(1) << win_idx;
          owner_d   = win_idx;
          m_addr_d  = req_addr[7*win_idx +: 7];
          m_rw_d    = req_rw[win_idx];
          m_wdata_d = req_wdata[8*win_idx +: 8];
          state_d   = StStart;
        end
      end
      StStart: begin
        if (!m_busy) begin
          m_start_d = 1'b1;
          state_d   = StWait;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      StWait: begin
        if (m_done) begin
          rdata_d = m_rdata;
          nack_d  = m_nack;
          done_d  = gnt_q;
          state_d = StDone;
`ifdef I2C_ARB_TIMEOUT_EN
          timeout_d = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          // Expiry on the TIMEOUT_CYC-th WAIT cycle; a coincident M_done wins above.
          rdata_d   = 8'h00;
          nack_d    = 1'b1;
          timeout_d = 1'b1;
          done_d    = gnt_q;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        gnt_d   = '0;
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      nack_q    <= 1'b0;
      rdata_q   <= 8'h00;
      m_start_q <= 1'b0;
      m_addr_q  <= 7'h00;
      m_rw_q    <= 1'b0;
      m_wdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
      rdata_q   <= rdata_d;
      m_start_q <= m_start_d;
      m_addr_q  <= m_addr_d;
      m_rw_q    <= m_rw_d;
      m_wdata_q <= m_wdata_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign nack    = nack_q;
  assign rdata   = rdata_q;
  assign m_start = m_start_q;
  assign m_addr  = m_addr_q;
  assign m_rw    = m_rw_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: stimulus pushes expected start/done records,
// a negedge monitor pops and compares them whenever M_start or Done is presented.
module tb_i2c_req_arbiter;
  localparam int unsigned NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ-1:0]   req_rw;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, done;
  logic              nack, timeout, m_start, m_rw;
  logic [7:0]        rdata, m_wdata;
  logic [6:0]        m_addr;
  logic              m_busy = 1'b0, m_done = 1'b0, m_nack = 1'b0;
  logic [7:0]        m_rdata = 8'h00;

  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .nack(nack), .rdata(rdata),
    .timeout(timeout), .m_start(m_start), .m_addr(m_addr), .m_rw(m_rw),
    .m_wdata(m_wdata), .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack),
    .m_rdata(m_rdata)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [6:0] a;
    logic       rw;
    logic [7:0] wd;
  } start_t;

  typedef struct packed {
    logic [3:0] d;
    logic       nk;
    logic [7:0] rd;
    logic       to;
  } done_t;

  start_t start_q[$];
  done_t  done_q[$];
  start_t s_exp;
  done_t  d_exp;
  int     checks = 0;
  int     errors = 0;

  logic [6:0] addr_tab [NREQ] = '{7'h50, 7'h51, 7'h52, 7'h53};
  logic [7:0] wd_tab   [NREQ] = '{8'hA5, 8'hA6, 8'hA7, 8'hA8};
  logic [3:0] rw_tab = 4'b0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_a"}, 32'({gnt, done, nack, rdata, timeout, m_start}), 32'h0);
    chk({name, "_b"}, 32'({m_addr, m_rw, m_wdata}), 32'h0);
  endtask

  task automatic push_start(input int i);
    start_t s;
    s.g  = 4'(1 << i);
    s.a  = addr_tab[i];
    s.rw = rw_tab[i];
    s.wd = wd_tab[i];
    start_q.push_back(s);
  endtask

  task automatic push_done(input int i, input logic nk, input logic [7:0] rd, input logic to);
    done_t d;
    d.d  = 4'(1 << i);
    d.nk = nk;
    d.rd = rd;
    d.to = to;
    done_q.push_back(d);
  endtask

  // Bounded wait for M_start, sampled on negedges.
  task automatic wait_start();
    int n = 0;
    while (!m_start && n <= 200) begin
      @(negedge clk);
      n++;
    end
    if (!m_start) chk("wait_start_timeout", 32'(n), 32'd0);
  endtask

  // Master model: M_done dly cycles after M_start; returns on the negedge Done is shown.
  task automatic serve(input int dly, input logic nk, input logic [7:0] rd);
    wait_start();
    repeat (dly) @(negedge clk);
    m_done  = 1'b1;
    m_nack  = nk;
    m_rdata = rd;
    @(negedge clk);
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
  endtask

  task automatic txn(input int i, input int dly, input logic nk, input logic [7:0] rd);
    push_start(i);
    push_done(i, nk, rd, 1'b0);
    serve(dly, nk, rd);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_start) begin
        if (start_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: gnt=%b, expected no start", gnt);
        end else begin
          s_exp = start_q.pop_front();
          chk("start_gnt", 32'(gnt), 32'(s_exp.g));
          chk("start_addr", 32'(m_addr), 32'(s_exp.a));
          chk("start_rw", 32'(m_rw), 32'(s_exp.rw));
          chk("start_wdata", 32'(m_wdata), 32'(s_exp.wd));
        end
      end
      if (|done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=%b, expected no done", done);
        end else begin
          d_exp = done_q.pop_front();
          chk("done_owner", 32'(done), 32'(d_exp.d));
          chk("done_nack", 32'(nack), 32'(d_exp.nk));
          chk("done_rdata", 32'(rdata), 32'(d_exp.rd));
          chk("done_timeout", 32'(timeout), 32'(d_exp.to));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    logic bad;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[7*i +: 7]  = addr_tab[i];
      req_wdata[8*i +: 8] = wd_tab[i];
    end
    req_rw = rw_tab;

    repeat (3) @(negedge clk);
    chk_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    // Basic write by requester 0 with latency checks.
    push_start(0);
    push_done(0, 1'b0, 8'h00, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt_latency", 32'(gnt), 32'b0001);
    chk("t1_no_early_start", 32'(m_start), 32'd0);
    @(negedge clk);
    chk("t1_start_latency", 32'(m_start), 32'd1);
    serve(10, 1'b0, 8'h00);
    chk("t1_done_latency", 32'(done), 32'b0001);
    req = 4'b0000;

    // Pointer is now 1: requester 3 wins over 0, then reset mid-WAIT.
    push_start(3);
    req = 4'b1001;
    wait_start();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    push_start(0);
    push_done(0, 1'b0, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regrant_from_0", 32'(gnt), 32'b0001);
    serve(3, 1'b0, 8'h11);
    req = 4'b1000;
    txn(3, 5, 1'b0, 8'h22);
    req = 4'b0000;

    // All requesters held high: 0,1,2,3,0 with an idle cycle between grants.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      txn(k % 4, 2, 1'b0, 8'h00);
      if (k == 4) req = 4'b0000;
      @(negedge clk);
      chk("rr_idle_gap", 32'(gnt), 32'd0);
    end

    // Requester 2 read with NACK; data must persist after Done.
    req = 4'b0100;
    txn(2, 4, 1'b1, 8'h3C);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'h3C);
    chk("nack_hold", 32'(nack), 32'd1);

    // Master busy for 20 cycles while in START.
    push_start(1);
    push_done(1, 1'b0, 8'h77, 1'b0);
    m_busy = 1'b1;
    req = 4'b0010;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_start) bad = 1'b1;
    end
    chk("busy_holds_start", 32'(bad), 32'd0);
    m_busy = 1'b0;
    @(negedge clk);
    chk("start_after_busy", 32'(m_start), 32'd1);
    serve(3, 1'b0, 8'h77);
    req = 4'b0000;
    @(negedge clk);
    chk("start_single_pulse", 32'(m_start), 32'd0);

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: no M_done, expect Done after exactly 100 WAIT cycles.
    push_start(0);
    push_done(0, 1'b1, 8'h00, 1'b1);
    req = 4'b0001;
    wait_start();
    n = 0;
    while (!(|done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_wait_cycles", 32'(n), 32'd100);
    req = 4'b0010;
    txn(1, 3, 1'b0, 8'h5A);
    req = 4'b0000;
`endif

    repeat (5) @(negedge clk);
    chk("start_queue_empty", 32'(start_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
